// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU sharing controller: FSM states, ALU op codes
// and the default datapath width.
package alu_ctrl_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // ALU op codes, packed as {sub_en, opt[1:0]}
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational. A lone requester always
// wins; on contention ptr picks the winner. The pointer register lives in the
// caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       idx
);

  // Pick the winner index and form the matching one-hot grant
  always_comb begin
    idx = 1'b0;
    gnt = 2'b00;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ptr;
      default: idx = 1'b0;
    endcase
    if (req != 2'b00) begin
      gnt = idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two valid/ready requesters. One transaction
// is in flight at a time: accept, issue (one-cycle alu_en), wait ALU_LAT,
// capture, then hold the response until the granted requester takes it.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [5:0]            req_op,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy,
  output logic                  alu_en,
  output logic                  alu_clr,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic                  alu_sub_en,
  output logic [1:0]            alu_opt,
  input  logic [DATA_W-1:0]     alu_result
);

  localparam int              CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             gnt_idx;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       arb_gnt;
  logic             arb_idx;
  logic             accept;
  logic             capture;
  logic             rsp_hs;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign accept  = |req_ready;
  assign capture = (state == ST_WAIT) && (cnt == '0);
  assign rsp_hs  = (state == ST_RESP) && rsp_ready[gnt_idx];
  assign busy    = (state != ST_IDLE);
  assign alu_clr = ~clr;

  // Next-state and handshake outputs; req_ready is masked while in reset
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    alu_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          req_ready = arb_gnt;
        end
        if (arb_gnt != 2'b00) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_en    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[gnt_idx] = 1'b1;
        if (rsp_ready[gnt_idx]) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant index, round-robin pointer and latency counter
  always_ff @(posedge clk) begin
    if (!clr) begin
      gnt_idx <= 1'b0;
      rr_ptr  <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        gnt_idx <= arb_idx;
      end
      if (state == ST_ISSUE) begin
        cnt <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (rsp_hs) begin
        rr_ptr <= ~gnt_idx;
      end
    end
  end

  // Operand latch on accept (held afterwards) and result capture after the wait
  always_ff @(posedge clk) begin
    if (!clr) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sub_en <= 1'b0;
      alu_opt    <= 2'b00;
      rsp_data   <= '0;
    end else begin
      if (accept) begin
        alu_a                 <= arb_idx ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        alu_b                 <= arb_idx ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        {alu_sub_en, alu_opt} <= arb_idx ? req_op[5:3] : req_op[2:0];
      end
      if (capture) begin
        rsp_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a vector table of single transactions on
// an ALU_LAT=1 instance, hand-written contention / back-pressure / reset
// sequences, and an ALU_LAT=3 instance for the latency parameter.
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---- DUT with ALU_LAT=1
  logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [5:0]  req_op = '0;
  logic [31:0] rsp_data, alu_a, alu_b, alu_result;
  logic        busy, alu_en, alu_clr, alu_sub_en;
  logic [1:0]  alu_opt;

  alu_share_ctrl #(.DATA_W(32), .ALU_LAT(1)) u_dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy), .alu_en(alu_en),
    .alu_clr(alu_clr), .alu_a(alu_a), .alu_b(alu_b), .alu_sub_en(alu_sub_en),
    .alu_opt(alu_opt), .alu_result(alu_result)
  );

  // ---- DUT with ALU_LAT=3
  logic [1:0]  req_valid3 = '0, req_ready3, rsp_valid3, rsp_ready3 = '0;
  logic [63:0] req_a3 = '0, req_b3 = '0;
  logic [5:0]  req_op3 = '0;
  logic [31:0] rsp_data3, alu_a3, alu_b3, alu_result3;
  logic        busy3, alu_en3, alu_clr3, alu_sub_en3;
  logic [1:0]  alu_opt3;

  alu_share_ctrl #(.DATA_W(32), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .clr(clr), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .busy(busy3), .alu_en(alu_en3),
    .alu_clr(alu_clr3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_sub_en(alu_sub_en3),
    .alu_opt(alu_opt3), .alu_result(alu_result3)
  );

  // Behavioural ALU
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_SHIFT: return a << b[4:0];
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      default:  return a + b;
    endcase
  endfunction

  // One-stage registered ALU for the LAT=1 instance
  always_ff @(posedge clk) begin
    if (alu_clr) alu_result <= '0;
    else if (alu_en) alu_result <= alu_f({alu_sub_en, alu_opt}, alu_a, alu_b);
  end

  // Registered ALU plus two delay stages for the LAT=3 instance
  logic [31:0] p3_0, p3_1;
  always_ff @(posedge clk) begin
    if (alu_clr3) begin
      p3_0 <= '0; p3_1 <= '0; alu_result3 <= '0;
    end else begin
      if (alu_en3) p3_0 <= alu_f({alu_sub_en3, alu_opt3}, alu_a3, alu_b3);
      p3_1        <= p3_0;
      alu_result3 <= p3_1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int rq, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_a[rq*32 +: 32] = a;
    req_b[rq*32 +: 32] = b;
    req_op[rq*3 +: 3]  = op;
  endtask

  // Called at negedge+1; returns once req_ready is seen (checked before stepping)
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready != 2'b00) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid != 2'b00) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    #1 clr = 1'b1;
  endtask

  // Single transaction with cycle-exact timing checks; accept cycle is t
  task automatic txn(input string nm, input int rq, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] op, input logic [31:0] exp);
    bit ok;
    logic [1:0] oh;
    oh = 2'b01 << rq;
    @(negedge clk); #1;
    set_req(rq, a, b, op);
    req_valid[rq] = 1'b1;
    rsp_ready[rq] = 1'b1;
    #1;
    wait_ready(ok);
    check({nm, " ready_seen"}, 32'(ok), 32'd1);
    check({nm, " req_ready"}, 32'(req_ready), 32'(oh));
    @(negedge clk); #1;            // t+1
    req_valid[rq] = 1'b0;
    check({nm, " alu_en@t+1"}, 32'(alu_en), 32'd1);
    check({nm, " busy@t+1"}, 32'(busy), 32'd1);
    check({nm, " alu_a"}, alu_a, a);
    check({nm, " alu_b"}, alu_b, b);
    check({nm, " alu_op"}, 32'({alu_sub_en, alu_opt}), 32'(op));
    @(negedge clk); #1;            // t+2
    check({nm, " alu_en@t+2"}, 32'(alu_en), 32'd0);
    check({nm, " rsp_valid@t+2"}, 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;            // t+3
    check({nm, " busy@t+3"}, 32'(busy), 32'd1);
    check({nm, " rsp_valid@t+3"}, 32'(rsp_valid), 32'(oh));
    check({nm, " rsp_data"}, rsp_data, exp);
    @(negedge clk); #1;            // t+4, handshake done
    check({nm, " busy_after"}, 32'(busy), 32'd0);
    check({nm, " rsp_valid_after"}, 32'(rsp_valid), 32'd0);
    rsp_ready[rq] = 1'b0;
  endtask

  typedef struct {
    int          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    vecs[0] = '{0, 32'h0000_0057, 32'h0000_000E, OP_ADD,   32'h0000_0065};
    vecs[1] = '{1, 32'h0000_0001, 32'h0000_0002, OP_SUB,   32'hFFFF_FFFF};
    vecs[2] = '{0, 32'h0000_0003, 32'h0000_0004, OP_SHIFT, 32'h0000_0030};
    vecs[3] = '{1, 32'hF0F0_1234, 32'h0FF0_FF00, OP_AND,   32'h00F0_1200};
    vecs[4] = '{0, 32'h8000_0000, 32'h8000_0001, OP_ADD,   32'h0000_0001};

    // Reset state, with requests already valid
    req_valid = 2'b11;
    set_req(0, 32'h1111_1111, 32'h2222_2222, OP_ADD);
    repeat (2) @(negedge clk);
    #1;
    check("rst alu_clr", 32'(alu_clr), 32'd1);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst alu_en", 32'(alu_en), 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    req_valid = 2'b00;
    clr = 1'b1;
    #1;
    check("run alu_clr", 32'(alu_clr), 32'd0);

    // Vector table of single transactions
    foreach (vecs[i]) begin
      txn($sformatf("vec%0d", i), vecs[i].rq, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    end

    // Contention: both held valid, grants alternate starting with 0
    do_reset();
    set_req(0, 32'h5555_5555, 32'hAAAA_AAAA, OP_AND);
    set_req(1, 32'h5555_5555, 32'hAAAA_AAAA, OP_OR);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_ready(ok);
      check($sformatf("rr%0d ready_seen", k), 32'(ok), 32'd1);
      check($sformatf("rr%0d grant", k), 32'(req_ready), (k % 2) ? 32'd2 : 32'd1);
      @(negedge clk); #1;
      wait_rsp(ok);
      check($sformatf("rr%0d rsp_seen", k), 32'(ok), 32'd1);
      check($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), (k % 2) ? 32'd2 : 32'd1);
      check($sformatf("rr%0d rsp_data", k), rsp_data, (k % 2) ? 32'hFFFF_FFFF : 32'h0000_0000);
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Back-pressure on requester 0 with requester 1 pending
    @(negedge clk); #1;
    set_req(0, 32'h10, 32'h20, OP_ADD);
    set_req(1, 32'h5, 32'h3, OP_SUB);
    req_valid = 2'b01;
    #1;
    wait_ready(ok);
    check("bp ready0", 32'(req_ready), 32'd1);
    @(negedge clk); #1;
    req_valid = 2'b10;
    wait_rsp(ok);
    check("bp rsp_seen", 32'(ok), 32'd1);
    rsp_ready[1] = 1'b1;           // non-granted ready must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d rsp_data", i), rsp_data, 32'h30);
      check($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    #1;
    check("bp hs req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check("bp req1 accepted", 32'(req_ready), 32'd2);
    check("bp rsp_valid cleared", 32'(rsp_valid), 32'd0);
    rsp_ready[0] = 1'b0;
    @(negedge clk); #1;
    req_valid = 2'b00;
    wait_rsp(ok);
    check("bp req1 rsp_valid", 32'(rsp_valid), 32'd2);
    check("bp req1 rsp_data", rsp_data, 32'h2);
    @(negedge clk); #1;
    check("bp idle", 32'(busy), 32'd0);
    rsp_ready = 2'b00;

    // Reset in WAIT with rr_ptr=1 beforehand
    txn("pre_rst", 0, 32'h7, 32'h8, OP_ADD, 32'hF);
    @(negedge clk); #1;
    set_req(0, 32'hDEAD_0000, 32'h0000_BEEF, OP_OR);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    #1;
    wait_ready(ok);
    check("rst_mid ready", 32'(req_ready), 32'd1);
    @(negedge clk); #1;            // ISSUE
    req_valid = 2'b00;
    @(negedge clk); #1;            // WAIT
    check("rst_mid busy_wait", 32'(busy), 32'd1);
    clr = 1'b0;
    #1;
    check("rst_mid alu_clr", 32'(alu_clr), 32'd1);
    @(negedge clk); #1;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid alu_a", alu_a, 32'd0);
    req_valid = 2'b11;
    set_req(0, 32'h0000_0100, 32'h0000_0023, OP_ADD);
    set_req(1, 32'h0000_0200, 32'h0000_0001, OP_ADD);
    #1;
    check("rst_mid req_ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check("rst_mid no_rsp", 32'(rsp_valid), 32'd0);
    clr = 1'b1;
    #1;
    check("post_rst grant0", 32'(req_ready), 32'd1);
    @(negedge clk); #1;
    req_valid = 2'b00;             // requester 1 withdraws before being granted
    wait_rsp(ok);
    check("post_rst rsp_valid", 32'(rsp_valid), 32'd1);
    check("post_rst rsp_data", rsp_data, 32'h0000_0123);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("post_rst idle", 32'(busy), 32'd0);
    check("post_rst no_grant", 32'(req_ready), 32'd0);
    rsp_ready = 2'b00;

    // ALU_LAT=3 instance
    @(negedge clk); #1;
    req_a3[31:0] = 32'h0CC3_5D12;
    req_b3[31:0] = 32'h1248_EDB7;
    req_op3[2:0] = OP_ADD;
    rsp_ready3   = 2'b01;
    req_valid3   = 2'b01;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready3 != 2'b00) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    check("lat3 ready", 32'(req_ready3), 32'd1);
    @(negedge clk); #1;            // t+1
    req_valid3 = 2'b00;
    check("lat3 alu_en", 32'(alu_en3), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("lat3 t+%0d rsp_valid", i), 32'(rsp_valid3), 32'd0);
      check($sformatf("lat3 t+%0d busy", i), 32'(busy3), 32'd1);
      check($sformatf("lat3 t+%0d alu_en", i), 32'(alu_en3), 32'd0);
    end
    @(negedge clk); #1;            // t+5
    check("lat3 rsp_valid", 32'(rsp_valid3), 32'd1);
    check("lat3 rsp_data", rsp_data3, 32'h1F0C_4AC9);
    @(negedge clk); #1;
    check("lat3 idle", 32'(busy3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Sequencer/arbiter that shares one registered 32-bit ALU (ports en, clr, a, b, sub_en, opt, alu_result; result registered on clk when en=1) between two requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. The block holds ALU operands stable, pulses the ALU enable, waits the ALU latency, captures the result and returns it to the granted requester. Grants alternate round-robin between the two requesters.

Parameters:
DATA_W, 32, operand/result width (must match ALU width)
ALU_LAT, 1, cycles from the ALU enable cycle to the valid alu_result (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
clr  in  1  reset, synchronous, active-low
req_valid  in  2  per-requester request valid, bit i = requester i
req_ready  out  2  per-requester request accept
req_a  in  2*DATA_W  operand A; requester i at [i*DATA_W +: DATA_W]
req_b  in  2*DATA_W  operand B, packed the same way
req_op  in  6  3 bits per requester, {sub_en,opt[1:0]}
rsp_valid  out  2  per-requester result valid
rsp_ready  in  2  per-requester result accept
rsp_data  out  DATA_W  result; meaningful only for the requester whose rsp_valid bit is set
busy  out  1  high whenever state != IDLE
alu_en  out  1  ALU enable
alu_clr  out  1  ALU clear, active-high; high while clr=0
alu_a  out  DATA_W  ALU operand A, registered
alu_b  out  DATA_W  ALU operand B, registered
alu_sub_en  out  1  ALU subtract select, registered
alu_opt  out  2  ALU op select, registered
alu_result  in  DATA_W  ALU registered result

Behaviour:
- Reset (clr=0 at a rising edge): state=IDLE, rr_ptr=0 (requester 0 has priority), operand/op/result registers=0, rsp_valid=0, alu_en=0. alu_clr=~clr (combinational). Reset applies in any state; an in-flight transaction is discarded with no response. req_ready=0 while clr=0.
- States: IDLE, ISSUE, WAIT, RESP (encodings in package).
- IDLE: the grant goes to the single valid requester if only one is valid. If both are valid, it goes to the one selected by rr_ptr. req_ready[g]=1 combinationally for the granted requester only, in IDLE only. On that edge the block latches req_a/req_b/req_op of g into alu_a/alu_b/{alu_sub_en,alu_opt}, stores g, and moves to ISSUE. If no request is valid, it stays in IDLE.
- ISSUE: alu_en=1 for exactly this one cycle. A counter loads ALU_LAT-1. Next state is WAIT.
- WAIT: alu_en=0 and operands are held. When the counter is 0, alu_result is captured into rsp_data and the state moves to RESP. Otherwise the counter decrements.
- RESP: rsp_valid[g]=1 and rsp_data is held stable until rsp_ready[g]=1. On that handshake edge: rsp_valid goes to 0, rr_ptr=~g, and the state returns to IDLE. rsp_ready of the non-granted requester is ignored.
- Throughput: one transaction per ALU_LAT+3 cycles. With ALU_LAT=1: accept at cycle t, alu_en at t+1, capture at end of t+2, rsp_valid from t+3.
- Only one transaction is in flight. req_ready=0 in ISSUE, WAIT and RESP, so a requester holding valid simply waits.
- A requester may drop req_valid before it is accepted; no grant is made to it.
- Operand registers are not cleared after a transaction. alu_a/alu_b keep their last values.
- Arithmetic is done by the ALU only. This block performs no width changes.

Decomposition:
- Shared package alu_ctrl_pkg:
  - state encodings ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP (2 bits)
  - op encodings {sub_en,opt}: OP_ADD=3'b000, OP_SUB=3'b100, OP_SHIFT=3'b001, OP_AND=3'b010, OP_OR=3'b011
  - DATA_W default
- One sub-module, rr_arb2: 2-input round-robin arbiter with inputs req[1:0] and ptr, and outputs a one-hot grant plus the grant index. It is purely combinational; the pointer register stays in alu_share_ctrl.

Test Plan:
1. Single add: req0 sends a=0x57, b=0x0E, op=OP_ADD, rsp_ready=1 → req_ready[0] pulses at t, alu_en one cycle at t+1, rsp_valid[0] at t+3 with rsp_data=0x65; busy high t+1..t+3.
2. Subtract wrap: req1 sends a=0x1, b=0x2, op=OP_SUB → rsp_valid[1] with rsp_data=0xFFFFFFFF; rsp_valid[0] stays 0.
3. Contention: after reset, both requesters are held valid for 4 transactions (req0 op=OP_AND 0x55555555&0xAAAAAAAA, req1 op=OP_OR same operands) → grant order 0,1,0,1; responses alternate 0x00000000 and 0xFFFFFFFF.
4. Back-pressure: rsp_ready[0]=0 for 5 cycles in RESP → rsp_valid[0] and rsp_data held stable, req_ready=0 throughout, a pending req1 is accepted only in the cycle after the handshake.
5. Reset mid-operation: assert clr=0 during WAIT → next edge state=IDLE, rsp_valid=0, alu_clr=1, no response is issued; after clr=1 a new request completes normally with rr_ptr=0.
6. Latency parameter: ALU_LAT=3 with a delayed ALU model, add 0x0CC35D12+0x1248EDB7 → rsp_valid at t+5 with rsp_data=0x1F0C4AC9.
